// File: rtl/character_sprite_engine.sv
// character_sprite_engine
//   Per-player sprite renderer. Latches position/facing once per frame,
//   runs a frame-counted attack sequence (IDLE/STARTUP/ACTIVE/RECOVERY),
//   a hurt-flash timer, and draws the body plus a facing-aware hitbox.
// Ports:
//   clk, rst_n           pixel clock, async active-low reset
//   frame_tick           one-cycle pulse per frame (start of vblank)
//   video_on, hcnt, vcnt visible qualifier and current pixel coordinates
//   x_pos, y_pos, facing body top-left and direction, sampled on frame_tick
//   attack_req/kind      attack request level and type, sampled on frame_tick
//   hurt                 one-cycle hit pulse, any cycle
//   sprite_on, r, g, b   registered pixel output (1 clk latency)
//   attack_phase         0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY
//   hitbox_active        attack_phase == ACTIVE
//   hurt_active          hurt timer non-zero
module character_sprite_engine #(
   parameter int unsigned BODY_W     = 64,
   parameter int unsigned BODY_H     = 240,
   parameter int unsigned HIT_W      = 32,
   parameter int unsigned HIT_H      = 80,
   parameter int unsigned HIT_YOFF   = 80,
   parameter int unsigned STARTUP_FR = 5,
   parameter int unsigned ACTIVE_FR  = 2,
   parameter int unsigned RECOV_FR   = 16,
   parameter int unsigned HURT_FR    = 8,
   parameter logic [11:0] BODY_RGB   = 12'hF00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       video_on,
   input  logic [9:0] hcnt,
   input  logic [9:0] vcnt,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic       facing,
   input  logic       attack_req,
   input  logic [1:0] attack_kind,
   input  logic       hurt,
   output logic       sprite_on,
   output logic [3:0] r,
   output logic [3:0] g,
   output logic [3:0] b,
   output logic [1:0] attack_phase,
   output logic       hitbox_active,
   output logic       hurt_active
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STARTUP  = 2'd1,
      ACTIVE   = 2'd2,
      RECOVERY = 2'd3
   } phase_t;

   localparam logic [10:0] BW  = 11'(BODY_W);
   localparam logic [10:0] BH  = 11'(BODY_H);
   localparam logic [10:0] HW  = 11'(HIT_W);
   localparam logic [10:0] HH  = 11'(HIT_H);
   localparam logic [10:0] HYO = 11'(HIT_YOFF);

   phase_t     state, state_nx;
   logic [7:0] fc, fc_nx;
   logic [7:0] ht, ht_nx;
   logic [1:0] kind, kind_nx;
   logic [9:0] xs, ys;
   logic       fs;
   logic       par;

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         fc    <= '0;
         ht    <= '0;
         kind  <= '0;
         xs    <= '0;
         ys    <= '0;
         fs    <= 1'b0;
         par   <= 1'b0;
      end else begin
         state <= state_nx;
         fc    <= fc_nx;
         ht    <= ht_nx;
         kind  <= kind_nx;
         if (frame_tick) begin
            xs  <= x_pos;
            ys  <= y_pos;
            fs  <= facing;
            par <= ~par;
         end
      end
   end

   // ---------------- attack FSM / hurt timer ----------------
   // hurt overrides everything on its edge: timer reload without decrement,
   // attack cancelled, and any coincident attack_req is dropped.
   always_comb begin
      state_nx = state;
      fc_nx    = fc;
      ht_nx    = ht;
      kind_nx  = kind;
      if (hurt) begin
         ht_nx    = 8'(HURT_FR);
         state_nx = IDLE;
         fc_nx    = '0;
      end else if (frame_tick) begin
         if (ht != '0) ht_nx = ht - 8'd1;
         case (state)
            IDLE: begin
               if (attack_req && (ht == '0)) begin
                  state_nx = STARTUP;
                  fc_nx    = 8'(STARTUP_FR - 1);
                  kind_nx  = attack_kind;
               end
            end
            STARTUP: begin
               if (fc == '0) begin
                  state_nx = ACTIVE;
                  fc_nx    = 8'(ACTIVE_FR - 1);
               end else fc_nx = fc - 8'd1;
            end
            ACTIVE: begin
               if (fc == '0) begin
                  state_nx = RECOVERY;
                  fc_nx    = 8'(RECOV_FR - 1);
               end else fc_nx = fc - 8'd1;
            end
            RECOVERY: begin
               if (fc == '0) begin
                  state_nx = IDLE;
                  fc_nx    = '0;
               end else fc_nx = fc - 8'd1;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign attack_phase  = state;
   assign hitbox_active = (state == ACTIVE);
   assign hurt_active   = (ht != '0);

   // ---------------- pixel path ----------------
   // 11-bit compares so edges past 1023 never wrap back onto the screen.
   logic [10:0] h11, v11, x11, y11, hit_lo, hit_hi;
   logic        in_body, in_hit, pix_on;
   logic [11:0] body_rgb, hit_rgb, pix_rgb;

   always_comb begin
      h11 = {1'b0, hcnt};
      v11 = {1'b0, vcnt};
      x11 = {1'b0, xs};
      y11 = {1'b0, ys};
      if (fs) begin
         hit_lo = (x11 >= HW) ? (x11 - HW) : '0;
         hit_hi = x11;
      end else begin
         hit_lo = x11 + BW;
         hit_hi = x11 + BW + HW;
      end
      in_body = (h11 >= x11) && (h11 < x11 + BW) &&
                (v11 >= y11) && (v11 < y11 + BH);
      in_hit  = (state == ACTIVE) &&
                (h11 >= hit_lo) && (h11 < hit_hi) &&
                (v11 >= y11 + HYO) && (v11 < y11 + HYO + HH);
      pix_on  = video_on && (in_body || in_hit);

      body_rgb = (hurt_active && par) ? 12'hFFF : BODY_RGB;
      case (kind)
         2'd1:    hit_rgb = 12'h00F;
         2'd2:    hit_rgb = 12'hF80;
         default: hit_rgb = 12'h0F0;
      endcase
      pix_rgb = in_body ? body_rgb : hit_rgb;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sprite_on <= 1'b0;
         {r, g, b} <= '0;
      end else begin
         sprite_on <= pix_on;
         {r, g, b} <= pix_on ? pix_rgb : '0;
      end
   end

endmodule

// File: tb/tb_character_sprite_engine.sv
module tb_character_sprite_engine;

   logic       clk, rst_n, frame_tick, video_on, facing, attack_req, hurt;
   logic [9:0] hcnt, vcnt, x_pos, y_pos;
   logic [1:0] attack_kind;
   logic       sprite_on, hitbox_active, hurt_active;
   logic [3:0] r, g, b;
   logic [1:0] attack_phase;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned ntick = 0;
   int unsigned hb_frames;

   typedef struct {
      string       tag;
      logic [12:0] exp;
   } exp_t;
   exp_t sb[$];

   character_sprite_engine #(
      .STARTUP_FR(5), .ACTIVE_FR(2), .RECOV_FR(16), .HURT_FR(8), .BODY_RGB(12'hF00)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .video_on(video_on),
      .hcnt(hcnt), .vcnt(vcnt), .x_pos(x_pos), .y_pos(y_pos), .facing(facing),
      .attack_req(attack_req), .attack_kind(attack_kind), .hurt(hurt),
      .sprite_on(sprite_on), .r(r), .g(g), .b(b), .attack_phase(attack_phase),
      .hitbox_active(hitbox_active), .hurt_active(hurt_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      frame_tick = 1'b1;
      video_on   = 1'b0;
      @(negedge clk);
      frame_tick = 1'b0;
      ntick++;
   endtask

   // drive one pixel, record expectation, compare 1 clk later
   task automatic pix(input string tag, input int h, input int v, input logic on,
                      input logic [11:0] rgb);
      exp_t e;
      @(negedge clk);
      hcnt     = 10'(h);
      vcnt     = 10'(v);
      video_on = 1'b1;
      sb.push_back('{tag, {on, on ? rgb : 12'h000}});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk(e.tag, {3'b0, sprite_on, r, g, b}, {3'b0, e.exp});
      video_on = 1'b0;
   endtask

   function automatic logic [1:0] exp_phase(input int k);
      if (k < 5)       return 2'd1;
      else if (k < 7)  return 2'd2;
      else if (k < 23) return 2'd3;
      else             return 2'd0;
   endfunction

   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; video_on = 1'b0; facing = 1'b0;
      attack_req = 1'b0; hurt = 1'b0; hcnt = '0; vcnt = '0;
      x_pos = '0; y_pos = '0; attack_kind = '0;
      repeat (3) @(negedge clk);
      chk("rst_out", {9'b0, sprite_on, r, g, b}, 16'h0);
      chk("rst_phase", {14'b0, attack_phase}, 16'h0);
      chk("rst_flags", {14'b0, hitbox_active, hurt_active}, 16'h0);
      rst_n = 1'b1;

      // idle rendering at (100,200)
      x_pos = 10'd100; y_pos = 10'd200; facing = 1'b0;
      repeat (10) tick();
      chk("idle_phase", {14'b0, attack_phase}, 16'h0);
      pix("body_tl",    100, 200, 1'b1, 12'hF00);
      pix("body_br",    163, 439, 1'b1, 12'hF00);
      pix("left_out",    99, 300, 1'b0, 12'h000);
      pix("right_out",  164, 300, 1'b0, 12'h000);
      pix("top_out",    120, 199, 1'b0, 12'h000);
      pix("bot_out",    120, 440, 1'b0, 12'h000);
      pix("idle_nohit", 170, 300, 1'b0, 12'h000);

      // attack kind 1, facing right
      attack_req = 1'b1; attack_kind = 2'd1;
      tick();
      attack_req = 1'b0;
      hb_frames = 0;
      for (int k = 0; k <= 24; k++) begin
         if (k > 0) tick();
         chk($sformatf("atk_phase_k%0d", k), {14'b0, attack_phase}, {14'b0, exp_phase(k)});
         if (hitbox_active) hb_frames++;
         if (k == 5) begin
            attack_req = 1'b1;   // ignored while busy
            pix("hit_px",     170, 300, 1'b1, 12'h00F);
            pix("hit_body",   163, 300, 1'b1, 12'hF00);
            pix("hit_r_edge", 196, 300, 1'b0, 12'h000);
            pix("hit_v_top",  170, 279, 1'b0, 12'h000);
            pix("hit_v_bot",  170, 360, 1'b0, 12'h000);
         end
         if (k == 6) attack_req = 1'b0;
      end
      chk("hb_frames", 16'(hb_frames), 16'd2);

      // facing left at xs=10, kind 2
      x_pos = 10'd10; facing = 1'b1; attack_kind = 2'd2; attack_req = 1'b1;
      tick();
      attack_req = 1'b0;
      repeat (5) tick();
      chk("left_phase", {14'b0, attack_phase}, 16'h2);
      pix("left_h0",    0, 300, 1'b1, 12'hF80);
      pix("left_h9",    9, 300, 1'b1, 12'hF80);
      pix("left_body", 10, 300, 1'b1, 12'hF00);
      pix("left_nowrap1000", 1000, 300, 1'b0, 12'h000);
      pix("left_nowrap1023", 1023, 300, 1'b0, 12'h000);
      repeat (18) tick();
      chk("left_done", {14'b0, attack_phase}, 16'h0);

      // xs=1000 facing right: body clipped at 1023, no wrap
      x_pos = 10'd1000; facing = 1'b0;
      tick();
      pix("edge_1023", 1023, 439, 1'b1, 12'hF00);
      pix("edge_999",   999, 300, 1'b0, 12'h000);
      pix("edge_wrap0",   0, 300, 1'b0, 12'h000);
      pix("edge_wrap39", 39, 300, 1'b0, 12'h000);

      // hurt during ACTIVE
      x_pos = 10'd100; attack_kind = 2'd0; attack_req = 1'b1;
      tick();
      attack_req = 1'b0;
      repeat (5) tick();
      chk("pre_hurt_phase", {14'b0, attack_phase}, 16'h2);
      pix("k0_hit", 170, 300, 1'b1, 12'h0F0);
      @(negedge clk); hurt = 1'b1;
      @(posedge clk); #1;
      chk("hurt_phase", {14'b0, attack_phase}, 16'h0);
      chk("hurt_flags", {14'b0, hitbox_active, hurt_active}, 16'h1);
      @(negedge clk); hurt = 1'b0;
      pix("hurt_col0", 120, 300, 1'b1, (ntick % 2 == 1) ? 12'hFFF : 12'hF00);
      attack_req = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("hurt_act_%0d", i), {15'b0, hurt_active}, {15'b0, (i < 8)});
         chk($sformatf("hurt_noatk_%0d", i), {14'b0, attack_phase}, 16'h0);
         pix($sformatf("hurt_col_%0d", i), 120, 300, 1'b1,
             ((i < 8) && (ntick % 2 == 1)) ? 12'hFFF : 12'hF00);
      end
      attack_req = 1'b0;

      // hurt coincident with frame_tick and attack_req
      @(negedge clk);
      hurt = 1'b1; frame_tick = 1'b1; attack_req = 1'b1;
      @(negedge clk);
      hurt = 1'b0; frame_tick = 1'b0; attack_req = 1'b0;
      ntick++;
      chk("coin_phase", {14'b0, attack_phase}, 16'h0);
      chk("coin_hurt", {15'b0, hurt_active}, 16'h1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("coin_act_%0d", i), {15'b0, hurt_active}, {15'b0, (i < 8)});
      end

      // x change mid-frame is invisible until next tick
      x_pos = 10'd500;
      pix("shadow_old", 120, 300, 1'b1, 12'hF00);
      pix("shadow_new_off", 500, 300, 1'b0, 12'h000);
      tick();
      pix("shadow_old_off", 120, 300, 1'b0, 12'h000);
      pix("shadow_new", 500, 300, 1'b1, 12'hF00);

      // async reset mid-recovery
      attack_req = 1'b1;
      tick();
      attack_req = 1'b0;
      repeat (7) tick();
      chk("rec_phase", {14'b0, attack_phase}, 16'h3);
      @(negedge clk);
      hcnt = 10'd520; vcnt = 10'd300; video_on = 1'b1;
      @(posedge clk); #1;
      chk("pre_rst_on", {15'b0, sprite_on}, 16'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out", {9'b0, sprite_on, r, g, b}, 16'h0);
      chk("arst_phase", {14'b0, attack_phase}, 16'h0);
      chk("arst_flags", {14'b0, hitbox_active, hurt_active}, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/character_sprite_engine.md
# character_sprite_engine

Parametrised per-player sprite renderer with an internal frame-driven attack state machine, hurt-flash timer and facing-aware hitbox. It sits between the player input/game-logic block and the VGA pixel mux, one instance per player. It latches player position once per video frame to avoid tearing and sequences startup/active/recovery attack phases itself. It produces registered RGB and a sprite mask plus hitbox status for collision logic.

## Interface
- BODY_W, 64, body width in pixels
- BODY_H, 240, body height in pixels
- HIT_W, 32, hitbox width in pixels
- HIT_H, 80, hitbox height in pixels
- HIT_YOFF, 80, hitbox top offset below body top
- STARTUP_FR, 5, startup phase length in frames (1..255)
- ACTIVE_FR, 2, active phase length in frames (1..255)
- RECOV_FR, 16, recovery phase length in frames (1..255)
- HURT_FR, 8, hurt-flash length in frames (1..255)
- BODY_RGB, 12'hF00, body colour {r,g,b}
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- frame_tick  in  1  one-cycle pulse, once per frame at start of vertical blanking
- video_on  in  1  visible-area qualifier
- hcnt, vcnt  in  10 each  current pixel coordinates
- x_pos, y_pos  in  10 each  body top-left, sampled only on frame_tick
- facing  in  1  0 = right, 1 = left; sampled only on frame_tick
- attack_req  in  1  level; sampled only on frame_tick
- attack_kind  in  2  attack type; latched with accepted request
- hurt  in  1  one-cycle pulse, any cycle
- sprite_on  out  1  registered: pixel is body or drawn hitbox
- r, g, b  out  4 each  registered colour; 0 when sprite_on = 0
- attack_phase  out  2  0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY
- hitbox_active  out  1  attack_phase == ACTIVE
- hurt_active  out  1  hurt timer non-zero

## Operation
- Shadow regs xs, ys, fs load x_pos, y_pos, facing on frame_tick; all geometry uses shadows.
- Attack FSM, 8-bit frame counter fc; it advances on frame_tick only:
  - IDLE: on frame_tick with attack_req=1 and hurt_active=0 -> STARTUP, fc=STARTUP_FR-1, kind latched.
  - STARTUP/ACTIVE/RECOVERY: on frame_tick, if fc=0 go to the next phase (RECOVERY -> IDLE) and load that phase length-1; else fc-=1.
  - attack_req while not IDLE is ignored; nothing is queued.
- Hurt: hurt pulse loads hurt timer ht=HURT_FR and forces the FSM to IDLE on the same edge, cancelling the attack. ht decrements on each frame_tick while non-zero.
- hurt and frame_tick on the same cycle: hurt wins; ht loads HURT_FR with no decrement; any attack_req on that cycle is ignored.
- Geometry: all comparisons use 11-bit unsigned arithmetic, so there is no wrap past 1023.
  - Body: hcnt in [xs, xs+BODY_W), vcnt in [ys, ys+BODY_H).
  - Hitbox, right facing: hcnt in [xs+BODY_W, xs+BODY_W+HIT_W).
  - Hitbox, left facing: hcnt in [max(xs-HIT_W,0), xs).
  - Hitbox vertical: vcnt in [ys+HIT_YOFF, ys+HIT_YOFF+HIT_H).
- The hitbox is drawn only in the ACTIVE phase; body takes precedence on any overlap.
- Hitbox colour by kind: 0 = 0F0, 1 = 00F, 2 = F80, 3 = 0F0.
- Body colour: BODY_RGB. While hurt_active and frame parity bit = 1, body colour is FFF; the parity bit toggles on each frame_tick and resets to 0.

## Timing
- Reset: sprite_on=0, r=g=b=0, attack_phase=IDLE, hitbox_active=0, hurt_active=0, fc=0, ht=0, shadows=0, parity=0. Reset mid-attack or mid-hurt returns everything to these values immediately.
- Pixel path latency is 1 clk: outputs at edge k reflect hcnt/vcnt/video_on sampled at edge k-1. The downstream sync path must be delayed by 1 clk to match.
- Phase and hurt outputs are registered and change 1 clk after the frame_tick or hurt edge.
- Attack accepted at tick N gives: STARTUP for ticks N..N+S-1, ACTIVE from N+S, RECOVERY from N+S+A, IDLE from N+S+A+R (S, A, R = STARTUP_FR, ACTIVE_FR, RECOV_FR). Total length is exactly S+A+R frames.
- A new attack can be accepted on the same tick on which the FSM returns to IDLE only at the following tick, since IDLE is evaluated from registered state.

## Test plan
- Reset then idle: xs=100, ys=200, 10 frames, attack_req=0 -> sprite_on only for hcnt 100..163, vcnt 200..439 (output 1 clk late); colour F00; phase 0.
- Attack kind 1, facing right, defaults -> phase 1 for 5 ticks, then 2 for 2 ticks with pixel (170,300) = 00F, then 3 for 16 ticks, then 0; hitbox_active high exactly 2 frames.
- Facing left at xs=10 -> active hitbox covers hcnt 0..9 only, with no wrap at 1000+. xs=1000 facing right -> no pixels beyond hcnt 1023.
- hurt pulse during ACTIVE -> phase 0 next clk; hurt_active for 8 ticks; body alternates F00/FFF starting per parity; attack_req during hurt ignored.
- hurt coincident with frame_tick and attack_req -> ht=8 (no decrement), no attack started.
- Change x_pos mid-frame -> rendering unchanged until next frame_tick. Assert rst_n low mid-RECOVERY -> all outputs zero asynchronously.
